// File: rtl/reg_pipe_hs.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush and occupancy.
// Stage STAGES-1 drives the output; each stage keeps its data until a real transfer.
module reg_pipe_hs #(
  parameter int unsigned       WIDTH      = 40,
  parameter int unsigned       STAGES     = 2,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [$clog2(STAGES+1)-1:0]     occupancy
);

  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv, load, d_en;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [OccW-1:0]   occ_q, occ_d;
  logic              room;

  // A stage advances when it is valid and some slot at or below it can absorb a word;
  // equivalent to the recursive adv chain but without a self-referencing vector.
  always_comb begin
    adv  = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = v_q[i] & room;
      room   = room | ~v_q[i];
    end
    load = ~v_q | adv;
  end

  assign in_ready  = load[0] & ~flush & ~rst;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

  always_comb begin
    v_d     = v_q;
    d_en    = '0;
    d_en[0] = load[0] & in_valid;
    if (load[0]) begin
      v_d[0] = in_valid;
    end
    for (int i = 1; i < STAGES; i++) begin
      d_en[i] = load[i] & adv[i-1];
      if (load[i]) begin
        v_d[i] = v_q[i-1] & adv[i-1];
      end
    end
    if (flush) begin
      v_d  = '0;
      d_en = '0;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OccW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      d_q[0] <= RESET_DATA;
    end else if (d_en[0]) begin
      d_q[0] <= in_data;
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : gen_stage
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        d_q[g] <= RESET_DATA;
      end else if (d_en[g]) begin
        d_q[g] <= d_q[g-1];
      end
    end
  end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Directed checks on a 3-stage/40-bit instance and a scoreboarded random run on a
// 1-stage/8-bit instance.
module tb_reg_pipe_hs;

  localparam logic [39:0] Rd3 = 40'hA5_0000_005A;
  localparam logic [7:0]  Rd1 = 8'h3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush3, iv3, ir3, ov3, or3;
  logic [39:0] id3, od3;
  logic [1:0]  occ3;
  logic        flush1, iv1, ir1, ov1, or1;
  logic [7:0]  id1, od1;
  logic [0:0]  occ1;

  int checks = 0;
  int errors = 0;

  reg_pipe_hs #(.WIDTH(40), .STAGES(3), .RESET_DATA(Rd3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3)
  );

  reg_pipe_hs #(.WIDTH(8), .STAGES(1), .RESET_DATA(Rd1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush3 = 1'b0; flush1 = 1'b0;
    iv3 = 1'b1; id3 = 40'h77; or3 = 1'b0;
    iv1 = 1'b1; id1 = 8'h77; or1 = 1'b0;
    #1;
    checks++;
    if (ir3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", ir3); end
    tick;
    tick;
    checks++;
    if (ir3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hold got %b want 0", ir3); end
    rst = 1'b0; iv3 = 1'b0; iv1 = 1'b0;
    #1;
    checks++;
    if (occ3 !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ3); end
    checks++;
    if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov3); end
    checks++;
    if (od3 !== Rd3) begin errors++; $display("FAIL reset_out_data got %h want %h", od3, Rd3); end
    checks++;
    if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", ir3); end
    checks++;
    if (ov1 !== 1'b0 || occ1 !== 1'b0 || od1 !== Rd1) begin
      errors++;
      $display("FAIL reset_s1 got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", ov1, occ1, od1, Rd1);
    end
  endtask

  task automatic test_streaming;
    or3 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin iv3 = 1'b1; id3 = 40'(c + 1); end
      else iv3 = 1'b0;
      #1;
      checks++;
      if (ir3 !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d got %b want 1", c, ir3); end
      tick;
      checks++;
      if (ov3 !== (c >= 2 && c <= 11)) begin
        errors++;
        $display("FAIL stream_valid c=%0d got %b want %b", c, ov3, (c >= 2 && c <= 11));
      end
      if (c >= 2 && c <= 11) begin
        checks++;
        if (od3 !== 40'(c - 1)) begin
          errors++;
          $display("FAIL stream_data c=%0d got %h want %h", c, od3, 40'(c - 1));
        end
      end
    end
    checks++;
    if (occ3 !== 2'd0) begin errors++; $display("FAIL stream_drained got %0d want 0", occ3); end
  endtask

  task automatic test_full_stall;
    int acc;
    acc = 0;
    or3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iv3 = 1'b1; id3 = 40'(8'h11 + acc);
      #1;
      checks++;
      if (ir3 !== (k < 3)) begin errors++; $display("FAIL stall_ready k=%0d got %b want %b", k, ir3, (k < 3)); end
      if (ir3 === 1'b1) acc++;
      tick;
    end
    checks++;
    if (occ3 !== 2'd3) begin errors++; $display("FAIL stall_occ got %0d want 3", occ3); end
    checks++;
    if (ov3 !== 1'b1 || od3 !== 40'h11) begin
      errors++; $display("FAIL stall_head got v=%b d=%h want v=1 d=11", ov3, od3);
    end
    iv3 = 1'b0; or3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ov3 !== 1'b1 || od3 !== 40'(8'h11 + k)) begin
        errors++;
        $display("FAIL stall_drain k=%0d got v=%b d=%h want v=1 d=%h", k, ov3, od3, 40'(8'h11 + k));
      end
      tick;
    end
    checks++;
    if (ov3 !== 1'b0 || occ3 !== 2'd0) begin
      errors++; $display("FAIL stall_empty got v=%b occ=%0d want v=0 occ=0", ov3, occ3);
    end
  endtask

  task automatic test_bubble_collapse;
    or3 = 1'b0;
    iv3 = 1'b1; id3 = 40'hAA_AAAA_0001;
    tick;
    iv3 = 1'b0;
    tick;
    tick;
    checks++;
    if (ov3 !== 1'b1 || od3 !== 40'hAA_AAAA_0001) begin
      errors++; $display("FAIL bubble_a_head got v=%b d=%h want v=1 d=aaaaaa0001", ov3, od3);
    end
    iv3 = 1'b1; id3 = 40'hBB_BBBB_0002;
    #1;
    checks++;
    if (ir3 !== 1'b1) begin errors++; $display("FAIL bubble_b_ready got %b want 1", ir3); end
    tick;
    iv3 = 1'b0;
    checks++;
    if (occ3 !== 2'd2) begin errors++; $display("FAIL bubble_occ got %0d want 2", occ3); end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (ov3 !== 1'b1 || od3 !== 40'hAA_AAAA_0001 || occ3 !== 2'd2) begin
        errors++;
        $display("FAIL bubble_stable k=%0d got v=%b d=%h occ=%0d want v=1 d=aaaaaa0001 occ=2",
                 k, ov3, od3, occ3);
      end
    end
    or3 = 1'b1;
    tick;
    checks++;
    if (ov3 !== 1'b1 || od3 !== 40'hBB_BBBB_0002) begin
      errors++; $display("FAIL bubble_b_out got v=%b d=%h want v=1 d=bbbbbb0002", ov3, od3);
    end
    tick;
    checks++;
    if (ov3 !== 1'b0) begin errors++; $display("FAIL bubble_empty got %b want 0", ov3); end
  endtask

  task automatic test_flush;
    or3 = 1'b0;
    iv3 = 1'b1; id3 = 40'hC;
    tick;
    id3 = 40'hD;
    tick;
    checks++;
    if (occ3 !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occ3); end
    flush3 = 1'b1; id3 = 40'hE;
    #1;
    checks++;
    if (ir3 !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ir3); end
    tick;
    flush3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
    checks++;
    if (occ3 !== 2'd0 || ov3 !== 1'b0 || od3 !== Rd3) begin
      errors++;
      $display("FAIL flush_clear got occ=%0d v=%b d=%h want occ=0 v=0 d=%h", occ3, ov3, od3, Rd3);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (ov3 !== 1'b0) begin errors++; $display("FAIL flush_dropped k=%0d got v=%b d=%h", k, ov3, od3); end
    end
    iv3 = 1'b1; id3 = 40'hF;
    tick;
    iv3 = 1'b0;
    tick;
    tick;
    checks++;
    if (ov3 !== 1'b1 || od3 !== 40'hF) begin
      errors++; $display("FAIL flush_recover got v=%b d=%h want v=1 d=f", ov3, od3);
    end
    tick;
  endtask

  task automatic test_random_s1;
    logic [7:0] q[$];
    logic [7:0] next_w;
    logic [7:0] prev_od;
    logic       prev_stall;
    next_w = 8'h00; prev_stall = 1'b0; prev_od = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      iv1 = 1'($urandom_range(0, 1));
      or1 = ($urandom_range(0, 3) != 0);
      id1 = next_w;
      #1;
      checks++;
      if (ir1 !== (~ov1 | or1)) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, ir1, (~ov1 | or1));
      end
      if (prev_stall) begin
        checks++;
        if (ov1 !== 1'b1 || od1 !== prev_od) begin
          errors++;
          $display("FAIL rand_stable cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, ov1, od1, prev_od);
        end
      end
      if (ov1 === 1'b1 && or1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_dup cyc=%0d got d=%h want no output", cyc, od1);
        end else begin
          if (od1 !== q[0]) begin
            errors++; $display("FAIL rand_order cyc=%0d got %h want %h", cyc, od1, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (iv1 && ir1 === 1'b1) begin
        q.push_back(next_w);
        next_w = next_w + 8'd1;
      end
      prev_stall = (ov1 === 1'b1) && !or1;
      prev_od    = od1;
      tick;
      checks++;
      if (int'(occ1) != q.size() || ov1 !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_occ cyc=%0d got occ=%0d v=%b want %0d", cyc, occ1, ov1, q.size());
      end
    end
    iv1 = 1'b0; or1 = 1'b1;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_full_stall;
    test_bubble_collapse;
    test_flush;
    test_random_s1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
